ex_mult_div: RTL and testbench
==============================

// Module: ex_mult_div
// PURPOSE
//  EX-stage multiply/divide unit with architectural HI/LO registers.
//  Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO in parallel with the ALU.
//  HI/LO are read combinationally by MFHI/MFLO; the EX-stage mux routes them onto ALU_outE toward EX_MEM.
//  Drives busy so the hazard unit stalls IF/ID while an operation is in flight.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk      in   1   rising-edge clock, single domain
//  rst_n    in   1   asynchronous active-low reset
//  start    in   1   a valid MD op is in EX this cycle (already stall-qualified)
//  md_op    in   3   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op
//  srcA     in   32  rs operand (forwarded)
//  srcB     in   32  rt operand (forwarded)
//  busy     out  1   operation in flight; HI/LO not yet valid
//  hi       out  32  HI register
//  lo       out  32  LO register
// BEHAVIOUR
//  Reset (async, rst_n=0): hi=0, lo=0, busy=0, counter=0, pending results=0. Any in-flight op is discarded.
//  Idle accept: start=1 and busy=0 at edge t:
//   - MULT/MULTU/DIV/DIVU: latch the 64-bit result in pending regs; load counter with N-1;
//     busy=1 from edge t. N = MULT_CYCLES or DIV_CYCLES.
//   - MTHI: hi<=srcA at edge t. MTLO: lo<=srcA at edge t. busy stays 0.
//   - md_op 6/7: no effect.
//  In flight: counter decrements each edge. At the edge where counter==0 and busy=1:
//   - hi/lo <= pending; busy<=0.
//   - Net: busy is high for exactly N cycles. New hi/lo are visible the first cycle busy=0.
//  start=1 while busy=1: ignored entirely. This covers MTHI/MTLO too; the hazard unit must stall.
//  Same-edge completion plus start: completion commits first. The new start is ignored because busy was 1 at sample.
//  MULT: {hi,lo} = signed(srcA)*signed(srcB), 64-bit. MULTU: unsigned 64-bit product.
//  DIV: lo=quotient, hi=remainder; truncate toward zero; remainder takes the dividend's sign.
//  DIV overflow case 0x80000000 / -1: lo=0x80000000, hi=0.
//  DIVU: unsigned lo=A/B, hi=A%B.
//  Divide by zero (srcB=0, DIV or DIVU): full DIV_CYCLES busy; hi/lo left UNCHANGED at completion.
//  hi/lo are plain register outputs; no bypass from pending to outputs.
// STRUCTURE
//  Shared include md_defs.vh holds:
//   - md_op encodings (MD_MULT..MD_MTLO, MD_NOP)
//   - default MULT_CYCLES/DIV_CYCLES values
//  Sub-module md_calc (combinational):
//   - inputs: md_op, srcA, srcB
//   - outputs: {res_hi,res_lo}, div0 flag
//   - contains signed/unsigned mult and div
//  Top module owns: counter (width clog2 of the max cycle count), busy flag, pending regs, hi/lo.
// TESTING
//  1. Reset: drive rst_n=0 mid-DIV (counter=4) -> busy=0, hi=lo=0 immediately, with no clock edge needed.
//  2. MULT A=0xFFFFFFFE(-2), B=3 -> busy high 5 cycles.
//     Then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x2, lo=0xFFFFFFFA.
//  3. DIV A=-7, B=2 -> busy high 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//     DIVU 7/2 -> lo=3, hi=1.
//  4. Preload hi=0x11, lo=0x22 via MTHI/MTLO (each takes effect next cycle, busy=0).
//     Then DIV by 0 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
//  5. Start MULT; pulse start with MTLO srcA=0x55 on cycle 2 of busy -> ignored.
//     Final lo is the product, not 0x55.
//  6. Back-to-back: new MULT start on the first cycle busy=0 after a DIV -> accepted; busy re-asserts next cycle.

Source files
------------

// File: rtl/ex_mult_div_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// default latencies, result struct and small op-classification helpers.
package ex_mult_div_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NOP   = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/ex_mult_div_if.sv
// Request/result bundle between the EX stage (master) and the mult/div unit (slave).
interface ex_mult_div_if;

    logic        start;
    logic [2:0]  md_op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, srcA, srcB,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, srcA, srcB,
        output busy, hi, lo
    );

endinterface

// File: rtl/ex_mult_div_md_calc.sv
// Combinational datapath: one shared 64-bit multiplier and one unsigned
// divider on operand magnitudes, with signs reapplied afterwards.
module ex_mult_div_md_calc
    import ex_mult_div_pkg::*;
(
    input  logic [2:0]  i_md_op,
    input  logic [31:0] i_src_a,
    input  logic [31:0] i_src_b,
    output md_res_t     o_res,
    output logic        o_div0
);

    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        o_res    = '0;
        o_div0   = 1'b0;

        w_signed = (i_md_op == MD_MULT) || (i_md_op == MD_DIV);
        w_a_neg  = w_signed & i_src_a[31];
        w_b_neg  = w_signed & i_src_b[31];

        w_mul_a  = {{32{w_a_neg}}, i_src_a};
        w_mul_b  = {{32{w_b_neg}}, i_src_b};
        w_prod   = w_mul_a * w_mul_b;

        // Magnitude divide sidesteps the 0x80000000 / -1 overflow trap.
        w_a_mag  = w_a_neg ? -i_src_a : i_src_a;
        w_b_mag  = w_b_neg ? -i_src_b : i_src_b;
        w_b_safe = (w_b_mag == '0) ? 32'd1 : w_b_mag;
        w_quot   = w_a_mag / w_b_safe;
        w_rem    = w_a_mag % w_b_safe;

        if (is_div_op(i_md_op)) begin
            o_res.lo = (w_a_neg ^ w_b_neg) ? -w_quot : w_quot;
            o_res.hi = w_a_neg ? -w_rem : w_rem;
            o_div0   = (i_src_b == '0);
        end else if (is_mul_op(i_md_op)) begin
            o_res = w_prod;
        end
    end

endmodule

// File: rtl/ex_mult_div.sv
// EX-stage multiply/divide unit: HI/LO registers, pending result latch and a
// fixed-latency busy counter that the hazard unit uses to stall IF/ID.
module ex_mult_div
    import ex_mult_div_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_mult_div_if.slave   md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    md_res_t          r_pend;
    logic             r_pend_div0;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    md_res_t          w_res;
    logic             w_div0;
    logic             w_accept;
    logic             w_commit;

    ex_mult_div_md_calc u_calc (
        .i_md_op (md.md_op),
        .i_src_a (md.srcA),
        .i_src_b (md.srcB),
        .o_res   (w_res),
        .o_div0  (w_div0)
    );

    // A start seen while busy is dropped, including MTHI/MTLO.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = md.start;
                if (md.start && (is_mul_op(md.md_op) || is_div_op(md.md_op)))
                    w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the pending latch is reset too, so a discarded op leaves no stale result behind.
            r_pend      <= '0;
            r_pend_div0 <= 1'b0;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            if (w_commit && !r_pend_div0) begin
                r_hi <= r_pend.hi;
                r_lo <= r_pend.lo;
            end

            if (w_accept) begin
                case (md.md_op)
                    MD_MULT, MD_MULTU: begin
                        r_pend      <= w_res;
                        r_pend_div0 <= 1'b0;
                        r_cnt       <= MULT_LOAD;
                    end
                    MD_DIV, MD_DIVU: begin
                        r_pend      <= w_res;
                        r_pend_div0 <= w_div0;
                        r_cnt       <= DIV_LOAD;
                    end
                    MD_MTHI: r_hi <= md.srcA;
                    MD_MTLO: r_lo <= md.srcA;
                    default: ;
                endcase
            end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign md.busy = (r_state == ST_BUSY);
    assign md.hi   = r_hi;
    assign md.lo   = r_lo;

endmodule

// File: tb/tb_ex_mult_div.sv
// Self-checking bench for ex_mult_div: directed corner cases plus random ops
// compared against an arithmetic HI/LO model.
module tb_ex_mult_div;
    import ex_mult_div_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    ex_mult_div_if md_if ();

    ex_mult_div #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive busy samples, bounded so a stuck busy still terminates.
    task automatic wait_idle(output int n);
        n = 0;
        while (md_if.busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    // Reference model: architectural effect of one accepted op and its busy length.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n_exp);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n_exp = 0;
        case (op)
            3'd0: begin {exp_hi, exp_lo} = sa * sb; n_exp = MC; end
            3'd1: begin {exp_hi, exp_lo} = 64'(a) * 64'(b); n_exp = MC; end
            3'd2: begin
                n_exp = DC;
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    exp_lo = q[31:0];
                    exp_hi = r[31:0];
                end
            end
            3'd3: begin
                n_exp = DC;
                if (b != 0) begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_if.start = 1'b1;
        md_if.md_op = op;
        md_if.srcA  = a;
        md_if.srcB  = b;
    endtask

    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        int n_exp, n;
        model(op, a, b, n_exp);
        drive(op, a, b);
        tick();
        md_if.start = 1'b0;
        wait_idle(n);
        check({tag, ".busy"}, 32'(n), 32'(n_exp));
        check({tag, ".hi"}, md_if.hi, exp_hi);
        check({tag, ".lo"}, md_if.lo, exp_lo);
    endtask

    initial begin
        int          n_exp, n;
        logic [2:0]  op;
        logic [31:0] a, b;

        md_if.start = 1'b0;
        md_if.md_op = 3'd6;
        md_if.srcA  = '0;
        md_if.srcB  = '0;

        #2 rst_n = 1'b0;
        #1;
        check("reset.busy", 32'(md_if.busy), 32'd0);
        check("reset.hi", md_if.hi, 32'h0);
        check("reset.lo", md_if.lo, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        do_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3);
        do_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        do_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2);
        do_op("divu", MD_DIVU, 32'd7, 32'd2);

        do_op("mthi", MD_MTHI, 32'h11, 32'h0);
        do_op("mtlo", MD_MTLO, 32'h22, 32'h0);
        do_op("div0", MD_DIV, 32'd1234, 32'd0);
        do_op("divu0", MD_DIVU, 32'hFFFF_FFFF, 32'd0);
        do_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("mult_min", MD_MULT, 32'h8000_0000, 32'h8000_0000);
        do_op("nop7", 3'd7, 32'hDEAD_BEEF, 32'h1);

        // MTLO arriving on the second busy cycle must be dropped.
        model(MD_MULT, 32'd1000, 32'd77, n_exp);
        drive(MD_MULT, 32'd1000, 32'd77);
        tick();
        drive(MD_MTLO, 32'h55, 32'h0);
        tick();
        md_if.start = 1'b0;
        wait_idle(n);
        check("ign_mtlo.busy", 32'(n + 1), 32'(n_exp));
        check("ign_mtlo.hi", md_if.hi, exp_hi);
        check("ign_mtlo.lo", md_if.lo, exp_lo);

        // Start on the completing edge: commit wins, MTHI is dropped.
        model(MD_DIVU, 32'd100, 32'd7, n_exp);
        drive(MD_DIVU, 32'd100, 32'd7);
        tick();
        md_if.start = 1'b0;
        repeat (DC - 1) tick();
        check("last_cyc.busy", 32'(md_if.busy), 32'd1);
        drive(MD_MTHI, 32'hDEAD, 32'h0);
        tick();
        md_if.start = 1'b0;
        check("same_edge.busy", 32'(md_if.busy), 32'd0);
        check("same_edge.hi", md_if.hi, exp_hi);
        check("same_edge.lo", md_if.lo, exp_lo);

        // Back-to-back: MULT issued on the first idle cycle after a DIV.
        do_op("b2b_div", MD_DIV, 32'hFFFF_FF00, 32'd9);
        do_op("b2b_mult", MD_MULT, 32'h1234_5678, 32'hFEDC_BA98);

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
            do_op($sformatf("rnd%0d", i), op, a, b);
        end

        // Async reset in the middle of a DIV (counter at 4) clears everything at once.
        do_op("pre_hi", MD_MTHI, 32'hAAAA, 32'h0);
        do_op("pre_lo", MD_MTLO, 32'hBBBB, 32'h0);
        drive(MD_DIV, 32'd100, 32'd7);
        tick();
        md_if.start = 1'b0;
        repeat (5) tick();
        check("mid_div.busy", 32'(md_if.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst.busy", 32'(md_if.busy), 32'd0);
        check("async_rst.hi", md_if.hi, 32'h0);
        check("async_rst.lo", md_if.lo, 32'h0);
        exp_hi = '0;
        exp_lo = '0;
        #1 rst_n = 1'b1;
        repeat (DC) tick();
        check("post_rst.busy", 32'(md_if.busy), 32'd0);
        check("post_rst.hi", md_if.hi, 32'h0);
        check("post_rst.lo", md_if.lo, 32'h0);
        do_op("post_rst_mult", MD_MULTU, 32'd65536, 32'd65536);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
